// File: rtl/mem_resp_pkg.sv
// mem_resp shared types: bus widths, FSM states, decode helpers.
// Imported by the responder, its interface and the bench.
package mem_resp_pkg;

  localparam int MEM_BUS_W  = 64;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_WAIT_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  function automatic logic is_misaligned(
    input logic [2:0] lsb
  );
    return lsb != 3'd0;
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bundle between the mem stage
// and the data-memory responder.
interface mem_resp_if
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = MEM_BUS_W,
  parameter int ADDR_W = MEM_ADDR_W
) ();

  logic                mem_req_i;
  logic                mem_we_i;
  logic [ADDR_W-1:0]   mem_raddr_i;
  logic [ADDR_W-1:0]   mem_waddr_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic [DATA_W/8-1:0] mem_wmask_i;
  logic                mem_ready_o;
  logic                mem_rvalid_o;
  logic [DATA_W-1:0]   mem_rdata_o;
  logic                mem_wack_o;
  logic                mem_err_o;

  modport master (
    output mem_req_i,
    output mem_we_i,
    output mem_raddr_i,
    output mem_waddr_i,
    output mem_wdata_i,
    output mem_wmask_i,
    input  mem_ready_o,
    input  mem_rvalid_o,
    input  mem_rdata_o,
    input  mem_wack_o,
    input  mem_err_o
  );

  modport slave (
    input  mem_req_i,
    input  mem_we_i,
    input  mem_raddr_i,
    input  mem_waddr_i,
    input  mem_wdata_i,
    input  mem_wmask_i,
    output mem_ready_o,
    output mem_rvalid_o,
    output mem_rdata_o,
    output mem_wack_o,
    output mem_err_o
  );

endinterface

// File: rtl/mem_ram_sp.sv
// Single-port synchronous data RAM with byte write enables.
// Read data is registered and holds until the next read.
module mem_ram_sp #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wmask,
  output logic [DATA_W-1:0]     q
);

  localparam int NB    = DATA_W / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < NB; b++) begin
          if (wmask[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_resp.sv
// Data-memory responder: one request in flight, programmable
// wait states, then a single-cycle rvalid/wack pulse.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = MEM_BUS_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  mem_resp_if.slave bus
);

  localparam int MW = DATA_W / 8;
  localparam int IW = DEPTH_LOG2;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  mem_state_e state;
  mem_state_e state_n;

  logic [3:0] cnt;
  logic [3:0] cnt_n;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [MW-1:0]     lat_wmask;
  logic              lat_err;

  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [MW-1:0]     cur_wmask;
  logic              cur_err;

  logic              accept;
  logic              commit;
  logic              rd_zero;
  logic [DATA_W-1:0] ram_q;

  assign accept = (state == ST_IDLE)
                & bus.mem_req_i
                & ~rst;

  // With zero wait states the commit edge is the
  // accept edge, so the RAM must see the live bus.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    cur_wmask = lat_wmask;
    if (state == ST_IDLE) begin
      cur_we    = bus.mem_we_i;
      cur_addr  = bus.mem_we_i ? bus.mem_waddr_i
                               : bus.mem_raddr_i;
      cur_wdata = bus.mem_wdata_i;
      cur_wmask = bus.mem_wmask_i;
    end
  end

  assign cur_err = is_misaligned(cur_addr[2:0])
                 | (|cur_addr[ADDR_W-1:IW+3]);

  assign lat_err = is_misaligned(lat_addr[2:0])
                 | (|lat_addr[ADDR_W-1:IW+3]);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (bus.mem_req_i) begin
          cnt_n   = WC;
          state_n = (WC == 4'd0) ? ST_RESP
                                 : ST_WAIT;
        end
      end
      (state == ST_WAIT): begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n = ST_RESP;
        end
      end
      (state == ST_RESP): begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  assign commit = ~rst & (state_n == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (accept) begin
      lat_we    <= bus.mem_we_i;
      lat_addr  <= bus.mem_we_i ? bus.mem_waddr_i
                                : bus.mem_raddr_i;
      lat_wdata <= bus.mem_wdata_i;
      lat_wmask <= bus.mem_wmask_i;
    end
  end

  // Forces rdata to zero after reset or a rejected read
  // without touching the RAM's own output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_zero <= 1'b1;
    end else if (commit && !cur_we) begin
      rd_zero <= cur_err;
    end
  end

  mem_ram_sp #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (commit & ~cur_err),
    .we    (cur_we),
    .addr  (cur_addr[IW+2:3]),
    .wdata (cur_wdata),
    .wmask (cur_wmask),
    .q     (ram_q)
  );

  assign bus.mem_ready_o  = (state == ST_IDLE);
  assign bus.mem_rvalid_o = (state == ST_RESP) & ~lat_we;
  assign bus.mem_wack_o   = (state == ST_RESP) & lat_we;
  assign bus.mem_err_o    = (state == ST_RESP) & lat_err;
  assign bus.mem_rdata_o  = rd_zero ? '0 : ram_q;

endmodule
